// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter in front of the on-chip memory slave.
// Master 0 is the instruction-fetch port and master 1 is the data port.
// Ownership lasts for a whole cyc tenure and is handed out round-robin.
// A watchdog turns a slave that never responds into a one-cycle bus error.
//
// Handshake: a tenure starts when the arbiter grants a master whose cyc_i is
// high. While that master owns the bus, its stb/adr/sel/dat/we pass straight
// to the slave, and the slave's ack/err/rty/dat pass straight back to it.
// A transfer completes in the cycle where stb and one of ack/err/rty are both
// high. The tenure ends at the first clock edge that samples the owner's cyc
// low. The arbiter then spends one IDLE cycle before it grants again.
// grant_o is the one-hot state of the FSM, so checkers can bind to it directly.
module wb_arbiter_2m #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0 (instruction fetch)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  // master 1 (data)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  // shared slave port
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  // current owner, one-hot; 00 = idle
  output logic [1:0]  grant_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;      // most recent owner; 1 so that m0 wins the first contention
  logic [CW-1:0] r_cnt;       // cycles the current strobe has waited for a slave response

  logic w_own;
  logic w_mst_stb;
  logic w_resp;
  logic w_timeout;

  assign w_own     = (r_state == OWN0) || (r_state == OWN1);
  assign w_mst_stb = (r_state == OWN0) ? m0_stb_i :
                     (r_state == OWN1) ? m1_stb_i : 1'b0;
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  // A slave response in the limit cycle wins, so no error is raised then.
  assign w_timeout = w_own & w_mst_stb & ~w_resp & (r_cnt == CW'(TIMEOUT));

  assign grant_o   = {r_state == OWN1, r_state == OWN0};

  // Next owner: in IDLE pick a requester (alternating on contention); an owner keeps the bus until its cyc drops.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = r_last ? OWN0 : OWN1;
        else if (m0_cyc_i)        w_next = OWN0;
        else if (m1_cyc_i)        w_next = OWN1;
      end
      OWN0:    if (!m0_cyc_i) w_next = IDLE;
      OWN1:    if (!m1_cyc_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and last-owner record; the owner is remembered when its tenure ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == OWN0 && !m0_cyc_i) r_last <= 1'b0;
      if (r_state == OWN1 && !m1_cyc_i) r_last <= 1'b1;
    end
  end

  // Watchdog: count unanswered strobe cycles; any response, idle strobe, timeout or owner change clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_own && s_stb_o && !w_resp) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Routing: the owner sees the slave combinationally; the other master and the idle bus see zeros.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (r_state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~w_timeout;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_timeout;
        m0_rty_o = s_rty_i;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~w_timeout;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_timeout;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: a 256-word memory slave model behind the arbiter,
// directed master transactions, and an expected-response queue per master.
// Responses are popped and compared in a separate negedge monitor.
module tb_wb_arbiter_2m;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- master-side stimulus ----------------
  logic        mc   [2];
  logic        ms   [2];
  logic        mw   [2];
  logic [31:0] ma   [2];
  logic [31:0] md   [2];
  logic [3:0]  msel [2];

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  // ---------------- slave model ----------------
  logic [31:0] mem [256];
  logic [31:0] s_rdat;
  logic        s_ack;
  logic        s_err;
  logic        s_rty = 1'b0;
  logic [7:0]  wcnt;
  logic [7:0]  slv_wait = 8'd0;   // extra wait states before the response
  logic        in_range;

  assign in_range = (s_adr_o < 32'd256);

  wb_arbiter_2m #(.TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_adr_i(ma[0]), .m0_sel_i(msel[0]),
    .m0_dat_i(md[0]), .m0_we_i(mw[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_adr_i(ma[1]), .m1_sel_i(msel[1]),
    .m1_dat_i(md[1]), .m1_we_i(mw[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
    .s_dat_o(s_dat_o), .s_we_o(s_we_o),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o)
  );

  // Memory slave: responds slv_wait+1 cycles after strobe; address 0xFC answers with err; out of range never answers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_err  <= 1'b0;
      s_rdat <= '0;
      wcnt   <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16] <= 32'hDEADBEEF;
    end else if (s_cyc_o && s_stb_o && !s_ack && !s_err && in_range) begin
      if (wcnt == slv_wait) begin
        wcnt <= '0;
        if (s_adr_o == 32'hFC) begin
          s_err <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          if (s_we_o) begin
            for (int b = 0; b < 4; b++)
              if (s_sel_o[b]) mem[s_adr_o[7:0]][8*b +: 8] <= s_dat_o[8*b +: 8];
          end else begin
            s_rdat <= mem[s_adr_o[7:0]];
          end
        end
      end else begin
        wcnt <= wcnt + 8'd1;
      end
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      wcnt  <= '0;
    end
  end

  // ---------------- scoreboard ----------------
  // entry: [33] compare data, [32] expect err (else ack), [31:0] data
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [33:0] e0, e1;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response cycle seen by a master must match the head of that master's queue.
  always @(negedge clk) begin
    if (m0_ack_o || m0_err_o || m0_rty_o) begin
      if (exp_q0.size() == 0) begin
        chk("m0_unexpected_resp", 64'({m0_rty_o, m0_err_o, m0_ack_o}), 64'd0);
      end else begin
        e0 = exp_q0.pop_front();
        chk("m0_resp", 64'({m0_rty_o, m0_err_o, m0_ack_o}), 64'({1'b0, e0[32], ~e0[32]}));
        if (e0[33]) chk("m0_dat", 64'(m0_dat_o), 64'(e0[31:0]));
      end
    end
    if (m1_ack_o || m1_err_o || m1_rty_o) begin
      if (exp_q1.size() == 0) begin
        chk("m1_unexpected_resp", 64'({m1_rty_o, m1_err_o, m1_ack_o}), 64'd0);
      end else begin
        e1 = exp_q1.pop_front();
        chk("m1_resp", 64'({m1_rty_o, m1_err_o, m1_ack_o}), 64'({1'b0, e1[32], ~e1[32]}));
        if (e1[33]) chk("m1_dat", 64'(m1_dat_o), 64'(e1[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic exp_err, input logic chk_dat, input logic [31:0] exp_dat,
                       input logic push);
    mc[m]   = 1'b1;
    ms[m]   = 1'b1;
    mw[m]   = we;
    ma[m]   = adr;
    md[m]   = dat;
    msel[m] = 4'hF;
    if (push) begin
      if (m == 0) exp_q0.push_back({chk_dat, exp_err, exp_dat});
      else        exp_q1.push_back({chk_dat, exp_err, exp_dat});
    end
  endtask

  // Waits (bounded) for a response to master m; lat counts negedges, the one before the next edge being 0.
  task automatic wait_resp(input int m, output int lat);
    logic r;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      r = (m == 0) ? (m0_ack_o | m0_err_o | m0_rty_o) : (m1_ack_o | m1_err_o | m1_rty_o);
      if (r) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: master %0d got no response, expected one within 60 cycles", m);
    end
  endtask

  task automatic done(input int m);
    step();
    ms[m] = 1'b0;
    mc[m] = 1'b0;
    mw[m] = 1'b0;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0;
      ma[m] = '0; md[m] = '0; msel[m] = '0;
    end

    // reset holds the bus idle even with a request present
    mc[0] = 1'b1; ms[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    mc[0] = 1'b0; ms[0] = 1'b0;
    rst = 1'b0;
    step();

    // single read by m0
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    wait_resp(0, lat);
    chk("t1_ack_latency", 64'(lat), 64'd2);
    chk("t1_grant", 64'(grant_o), 64'd1);
    chk("t1_s_adr", 64'(s_adr_o), 64'h10);
    done(0);
    step();
    chk("t1_idle_after", 64'(grant_o), 64'd0);

    // simultaneous requests after reset: m0 first, one IDLE cycle, then m1
    reset_dut();
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    wait_resp(0, lat);
    chk("t2_m0_first_latency", 64'(lat), 64'd2);
    done(0);
    @(negedge clk);
    chk("t2_release_cycle_grant", 64'(grant_o), 64'd1);
    chk("t2_release_cycle_s_cyc", 64'(s_cyc_o), 64'd0);
    @(negedge clk);
    chk("t2_idle_gap", 64'(grant_o), 64'd0);
    @(negedge clk);
    chk("t2_m1_granted", 64'(grant_o), 64'd2);
    wait_resp(1, lat);
    done(1);
    step();
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_m0_wins_again", 64'(grant_o), 64'd1);
    wait_resp(0, lat);
    done(0);
    wait_resp(1, lat);
    done(1);
    step();

    // no preemption: m0 writes three words while m1 waits, then m1 reads them back
    issue(1, 1'b0, 32'h1, 32'h0, 1'b0, 1'b1, 32'hA, 1'b1);
    issue(0, 1'b1, 32'h1, 32'hA, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_resp(0, lat);
    chk("t3_owner_w1", 64'(grant_o), 64'd1);
    step();
    issue(0, 1'b1, 32'h2, 32'hB, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_resp(0, lat);
    chk("t3_owner_w2", 64'(grant_o), 64'd1);
    step();
    issue(0, 1'b1, 32'h3, 32'hC, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_resp(0, lat);
    chk("t3_owner_w3", 64'(grant_o), 64'd1);
    done(0);
    wait_resp(1, lat);
    step();
    issue(1, 1'b0, 32'h2, 32'h0, 1'b0, 1'b1, 32'hB, 1'b1);
    wait_resp(1, lat);
    step();
    issue(1, 1'b0, 32'h3, 32'h0, 1'b0, 1'b1, 32'hC, 1'b1);
    wait_resp(1, lat);
    done(1);
    step();

    // watchdog: m1 reads just past the memory window
    issue(1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    wait_resp(1, lat);
    chk("t4_err_latency", 64'(lat), 64'd16);
    chk("t4_stb_forced_low", 64'(s_stb_o), 64'd0);
    chk("t4_cyc_kept", 64'(s_cyc_o), 64'd1);
    @(negedge clk);
    chk("t4_err_single_cycle", 64'(m1_err_o), 64'd0);
    chk("t4_stb_back", 64'(s_stb_o), 64'd1);
    done(1);
    step();

    // ack in the same cycle the count reaches the limit: ack wins, no error
    slv_wait = 8'd14;
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    wait_resp(0, lat);
    chk("t5_late_ack_latency", 64'(lat), 64'd16);
    chk("t5_stb_not_forced", 64'(s_stb_o), 64'd1);
    done(0);
    step();
    slv_wait = 8'd0;

    // slave error passes straight through
    issue(0, 1'b0, 32'hFC, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    wait_resp(0, lat);
    chk("t6_err_latency", 64'(lat), 64'd2);
    done(0);
    step();

    // asynchronous reset mid-tenure, then a normal m1 grant
    slv_wait = 8'd5;
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t7_pre_grant", 64'(grant_o), 64'd1);
    chk("t7_pre_stb", 64'(s_stb_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_grant", 64'(grant_o), 64'd0);
    chk("t7_rst_outputs", 64'({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o}), 64'd0);
    mc[0] = 1'b0; ms[0] = 1'b0;
    slv_wait = 8'd0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    wait_resp(1, lat);
    chk("t7_post_latency", 64'(lat), 64'd2);
    chk("t7_post_grant", 64'(grant_o), 64'd2);
    done(1);
    step();
    step();

    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence is ever stuck somewhere unbounded.
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
